// File: rtl/param_cpu_pkg.sv
// param_cpu_pkg: shared opcodes and FSM state encoding for param_cpu_core.
// Build option PARAM_CPU_CORE_STEP_EN enables the PAUSE state in the core.
package param_cpu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
    localparam logic [OPC_W-1:0] OP_AND = 4'd4;
    localparam logic [OPC_W-1:0] OP_OR  = 4'd5;
    localparam logic [OPC_W-1:0] OP_XOR = 4'd6;
    localparam logic [OPC_W-1:0] OP_STA = 4'd7;
    localparam logic [OPC_W-1:0] OP_OUT = 4'd8;
    localparam logic [OPC_W-1:0] OP_JMP = 4'd9;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'd10;
    localparam logic [OPC_W-1:0] OP_JC  = 4'd11;
    localparam logic [OPC_W-1:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT,
        PAUSE
    } cpu_state_e;

endpackage

// File: rtl/param_cpu_alu.sv
// param_cpu_alu: combinational accumulator ALU for param_cpu_core.
// Non-ALU opcodes pass the accumulator through; the core decides which
// flags are committed.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    // Result, carry/borrow and zero for the current opcode
    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (opcode)
            OP_LDA: result = operand;
            OP_ADD: {carry, result} = {1'b0, acc} + {1'b0, operand};
            OP_SUB: begin
                result = acc - operand;
                carry  = (acc < operand);
            end
            OP_AND: result = acc & operand;
            OP_OR:  result = acc | operand;
            OP_XOR: result = acc ^ operand;
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/param_cpu_core.sv
// param_cpu_core: parametrised accumulator CPU with fetch/execute FSM,
// preloadable IMEM/DMEM, Z/C flags, jumps and OUT_CH output registers.
// Build option PARAM_CPU_CORE_STEP_EN adds a 'step' input and a PAUSE
// state after every executed instruction.
module param_cpu_core
    import param_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OUT_CH = 4,
    localparam int unsigned INSTR_W = OPC_W + ADDR_W,
    localparam int unsigned SEL_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef PARAM_CPU_CORE_STEP_EN
    input  logic               step,
`endif
    input  logic               load,
    input  logic               is_instruction,
    input  logic [ADDR_W-1:0]  load_address,
    input  logic [INSTR_W-1:0] instr_input,
    input  logic [DATA_W-1:0]  cpu_input,
    input  logic [SEL_W-1:0]   out_sel,
    output logic [DATA_W-1:0]  output_value,
    output logic               out_valid,
    output logic [SEL_W-1:0]   out_index,
    output logic               busy,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [INSTR_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0]  dmem [DEPTH];
    logic [DATA_W-1:0]  out_regs [OUT_CH];

    cpu_state_e         state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  acc;
    logic               flag_z, flag_c;

    logic [OPC_W-1:0]   opcode;
    logic [ADDR_W-1:0]  operand_addr;
    logic [DATA_W-1:0]  mem_operand;
    logic [SEL_W-1:0]   out_slot;
    logic               stopped;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry, alu_zero;

    assign opcode       = ir[INSTR_W-1:ADDR_W];
    assign operand_addr = ir[ADDR_W-1:0];
    assign mem_operand  = dmem[operand_addr];
    assign out_slot     = SEL_W'(32'(operand_addr) % OUT_CH);
    assign stopped      = (state == IDLE) || (state == HALT);
    assign busy         = (state == FETCH) || (state == EXEC) || (state == PAUSE);
    assign halted       = (state == HALT);

    param_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .acc     (acc),
        .operand (mem_operand),
        .opcode  (opcode),
        .result  (alu_result),
        .carry   (alu_carry),
        .zero    (alu_zero)
    );

    // Combinational read of the selected output register
    always_comb begin
        output_value = '0;
        if (32'(out_sel) < OUT_CH) output_value = out_regs[out_sel];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: if (start) state_nxt = FETCH;
            FETCH:      state_nxt = EXEC;
            EXEC: begin
                if (opcode == OP_HLT) state_nxt = HALT;
`ifdef PARAM_CPU_CORE_STEP_EN
                else                  state_nxt = PAUSE;
`else
                else                  state_nxt = FETCH;
`endif
            end
`ifdef PARAM_CPU_CORE_STEP_EN
            PAUSE:      if (step) state_nxt = FETCH;
`endif
            default:    state_nxt = IDLE;
        endcase
    end

    // PC, IR, accumulator, flags and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            for (int unsigned i = 0; i < OUT_CH; i++) out_regs[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, HALT: if (start) pc <= '0;
                FETCH: begin
                    ir <= imem[pc];
                    pc <= pc + ADDR_W'(1);
                end
                EXEC: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            acc    <= alu_result;
                            flag_z <= alu_zero;
                            if (opcode == OP_ADD || opcode == OP_SUB) flag_c <= alu_carry;
                        end
                        OP_OUT: begin
                            out_regs[out_slot] <= acc;
                            out_valid          <= 1'b1;
                            out_index          <= out_slot;
                        end
                        OP_JMP: pc <= operand_addr;
                        OP_JZ:  if (flag_z) pc <= operand_addr;
                        OP_JC:  if (flag_c) pc <= operand_addr;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Memories: host preload while stopped, STA during execution; not reset
    always_ff @(posedge clk) begin
        if (load && stopped) begin
            if (is_instruction) imem[load_address] <= instr_input;
            else                dmem[load_address] <= cpu_input;
        end else if (state == EXEC && opcode == OP_STA) begin
            dmem[operand_addr] <= acc;
        end
    end

endmodule

// File: tb/tb_param_cpu_core.sv
// tb_param_cpu_core: instruction-level reference model of the CPU compared
// against the DUT every cycle, directed programs with literal expectations,
// then randomized programs with stray start/load/reset activity.
// Honours PARAM_CPU_CORE_STEP_EN when defined.
module tb_param_cpu_core;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int OC    = 4;
    localparam int SW    = 2;
    localparam int IW    = 4 + AW;
    localparam int DEPTH = 1 << AW;
    localparam int DMOD  = 1 << DW;
`ifdef PARAM_CPU_CORE_STEP_EN
    localparam int CPI = 3;
`else
    localparam int CPI = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
`ifdef PARAM_CPU_CORE_STEP_EN
    logic          step = 1'b1;
`endif
    logic          load = 1'b0;
    logic          is_instruction = 1'b0;
    logic [AW-1:0] load_address = '0;
    logic [IW-1:0] instr_input = '0;
    logic [DW-1:0] cpu_input = '0;
    logic [SW-1:0] out_sel = '0;
    logic [DW-1:0] output_value;
    logic          out_valid;
    logic [SW-1:0] out_index;
    logic          busy, halted;
    logic [AW-1:0] pc;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    param_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .OUT_CH(OC)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
`ifdef PARAM_CPU_CORE_STEP_EN
        .step           (step),
`endif
        .load           (load),
        .is_instruction (is_instruction),
        .load_address   (load_address),
        .instr_input    (instr_input),
        .cpu_input      (cpu_input),
        .out_sel        (out_sel),
        .output_value   (output_value),
        .out_valid      (out_valid),
        .out_index      (out_index),
        .busy           (busy),
        .halted         (halted),
        .pc             (pc)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    int m_imem [DEPTH];
    int m_dmem [DEPTH];
    int m_out  [OC];
    int m_pc, m_acc, m_ir, m_out_index;
    bit m_z, m_c, m_busy, m_halted, m_exec_next, m_paused, m_out_valid;

    task automatic m_reset();
        m_pc = 0; m_acc = 0; m_ir = 0; m_z = 0; m_c = 0;
        m_busy = 0; m_halted = 0; m_exec_next = 0; m_paused = 0;
        m_out_valid = 0; m_out_index = 0;
        for (int i = 0; i < OC; i++) m_out[i] = 0;
    endtask

    task automatic m_execute();
        int op, a, d, s;
        op = m_ir / DEPTH;
        a  = m_ir % DEPTH;
        d  = m_dmem[a];
        case (op)
            1: m_acc = d;
            2: begin s = m_acc + d; m_c = (s >= DMOD); m_acc = s % DMOD; end
            3: begin m_c = (m_acc < d); m_acc = (m_acc - d + DMOD) % DMOD; end
            4: m_acc = m_acc & d;
            5: m_acc = m_acc | d;
            6: m_acc = m_acc ^ d;
            7: m_dmem[a] = m_acc;
            8: begin m_out[a % OC] = m_acc; m_out_valid = 1; m_out_index = a % OC; end
            9: m_pc = a;
            10: if (m_z) m_pc = a;
            11: if (m_c) m_pc = a;
            15: begin m_busy = 0; m_halted = 1; end
            default: ;
        endcase
        if (op >= 1 && op <= 6) m_z = (m_acc == 0);
`ifdef PARAM_CPU_CORE_STEP_EN
        if (op != 15) m_paused = 1;
`endif
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reset();
        end else begin
            m_out_valid = 0;
            if (!m_busy) begin
                if (load) begin
                    if (is_instruction) m_imem[load_address] = int'(instr_input);
                    else                m_dmem[load_address] = int'(cpu_input);
                end
                if (start) begin
                    m_pc = 0; m_busy = 1; m_halted = 0; m_exec_next = 0; m_paused = 0;
                end
            end else if (m_paused) begin
`ifdef PARAM_CPU_CORE_STEP_EN
                if (step) m_paused = 0;
`endif
            end else if (!m_exec_next) begin
                m_ir = m_imem[m_pc];
                m_pc = (m_pc + 1) % DEPTH;
                m_exec_next = 1;
            end else begin
                m_exec_next = 0;
                m_execute();
            end
        end
    end

    // Every-cycle comparison of DUT against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("pc", int'(pc), m_pc);
            chk("busy", int'(busy), int'(m_busy));
            chk("halted", int'(halted), int'(m_halted));
            chk("out_valid", int'(out_valid), int'(m_out_valid));
            if (m_out_valid) chk("out_index", int'(out_index), m_out_index);
            chk("output_value", int'(output_value), m_out[out_sel]);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic int enc(input int op, input int a);
        return op * DEPTH + a;
    endfunction

    function automatic int rand_instr();
        int op;
        op = $urandom_range(0, 15);
        if ($urandom_range(0, 9) == 0) op = 15;
        return enc(op, $urandom_range(0, DEPTH - 1));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input bit is_i, input int addr, input int data);
        load = 1'b1;
        is_instruction = is_i;
        load_address = AW'(addr);
        instr_input = IW'(data);
        cpu_input = DW'(data);
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        load = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic run_watch(input int budget, output int n, output bit saw_valid,
                             output int vidx, output bit saw_wrap);
        int prev;
        n = 0; saw_valid = 0; vidx = -1; saw_wrap = 0;
        prev = int'(pc);
        while (!halted && n < budget) begin
            cyc();
            n++;
            if (out_valid) begin saw_valid = 1; vidx = int'(out_index); end
            if (prev == DEPTH - 1 && int'(pc) == 0) saw_wrap = 1;
            prev = int'(pc);
        end
    endtask

    function automatic int exp_cycles(input int ninstr);
        return ninstr * CPI - (CPI - 2);
    endfunction

    initial begin
        int  n, vidx;
        bit  sv, sw;

        m_reset();
        repeat (2) cyc();
        check_en = 1'b1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out0", int'(output_value), 0);
        reset = 1'b1;
        cyc();
        for (int a = 0; a < DEPTH; a++) ld(1, a, enc(0, 0));
        for (int a = 0; a < DEPTH; a++) ld(0, a, 0);

        // 5 + 3 -> out 0
        ld(0, 0, 5); ld(0, 1, 3);
        ld(1, 0, enc(1, 0)); ld(1, 1, enc(2, 1)); ld(1, 2, enc(8, 0)); ld(1, 3, enc(15, 0));
        out_sel = 0;
        do_start();
        run_watch(60, n, sv, vidx, sw);
        chk("t1_cycles", n, exp_cycles(4));
        chk("t1_saw_valid", int'(sv), 1);
        chk("t1_index", vidx, 0);
        chk("t1_value", int'(output_value), 8);
        chk("t1_halted", int'(halted), 1);

        // 3 - 5 borrows, JC taken -> out1 = 0xFE
        ld(0, 0, 3); ld(0, 1, 5);
        ld(1, 0, enc(1, 0)); ld(1, 1, enc(3, 1)); ld(1, 2, enc(11, 5)); ld(1, 3, enc(15, 0));
        ld(1, 4, enc(0, 0)); ld(1, 5, enc(8, 1)); ld(1, 6, enc(15, 0));
        out_sel = 1;
        do_start();
        run_watch(60, n, sv, vidx, sw);
        chk("t2_cycles", n, exp_cycles(5));
        chk("t2_out1", int'(output_value), 254);
        chk("t2_pc", int'(pc), 7);

        // countdown from 3
        ld(0, 0, 3); ld(0, 1, 1);
        ld(1, 0, enc(1, 0)); ld(1, 1, enc(3, 1)); ld(1, 2, enc(10, 4)); ld(1, 3, enc(9, 1));
        ld(1, 4, enc(8, 2)); ld(1, 5, enc(15, 0));
        out_sel = 2;
        do_start();
        run_watch(100, n, sv, vidx, sw);
        chk("t3_cycles", n, exp_cycles(11));
        chk("t3_out2", int'(output_value), 0);
        chk("t3_pc", int'(pc), 6);

        // pc wrap 31 -> 0, loads ignored while busy
        pulse_reset();
        ld(0, 4, 255);
        ld(1, 0, enc(11, 2)); ld(1, 1, enc(9, 29)); ld(1, 2, enc(15, 0));
        ld(1, 29, enc(1, 4)); ld(1, 30, enc(2, 4)); ld(1, 31, enc(0, 0));
        do_start();
        load = 1'b1; is_instruction = 1'b0; load_address = '0; cpu_input = 8'hAA;
        repeat (4) cyc();
        load = 1'b0;
        run_watch(60, n, sv, vidx, sw);
        chk("t4_cycles", n + 4, exp_cycles(7));
        chk("t4_wrap", int'(sw), 1);
        chk("t4_pc", int'(pc), 3);
        ld(1, 0, enc(1, 0)); ld(1, 1, enc(8, 3)); ld(1, 2, enc(15, 0));
        out_sel = 3;
        do_start();
        run_watch(60, n, sv, vidx, sw);
        chk("t4_dmem0_kept", int'(output_value), 3);

        // reset during EXEC of ADD, then rerun
        ld(0, 0, 5); ld(0, 1, 3);
        ld(1, 0, enc(1, 0)); ld(1, 1, enc(2, 1)); ld(1, 2, enc(8, 0)); ld(1, 3, enc(15, 0));
        out_sel = 0;
        do_start();
        repeat (CPI + 1) cyc();
        chk("t5_busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("t5_async_pc", int'(pc), 0);
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_out0", int'(output_value), 0);
        cyc();
        reset = 1'b1;
        cyc();
        do_start();
        run_watch(60, n, sv, vidx, sw);
        chk("t5_rerun_cycles", n, exp_cycles(4));
        chk("t5_rerun_value", int'(output_value), 8);

`ifdef PARAM_CPU_CORE_STEP_EN
        // single-step: one instruction per step pulse
        ld(1, 0, enc(1, 0)); ld(1, 1, enc(8, 0)); ld(1, 2, enc(15, 0));
        step = 1'b0;
        do_start();
        repeat (2) cyc();
        chk("st_pc1", int'(pc), 1);
        repeat (5) cyc();
        chk("st_hold_pc", int'(pc), 1);
        chk("st_hold_busy", int'(busy), 1);
        step = 1'b1; cyc(); step = 1'b0;
        repeat (3) cyc();
        chk("st_pc2", int'(pc), 2);
        step = 1'b1; cyc(); step = 1'b0;
        repeat (2) cyc();
        chk("st_halted", int'(halted), 1);
        chk("st_pc3", int'(pc), 3);
        step = 1'b1;
`endif

        // randomized programs with stray control activity
        for (int it = 0; it < 25; it++) begin
            if (busy) pulse_reset();
            for (int a = 1; a < DEPTH; a++) ld(1, a, rand_instr());
            for (int a = 0; a < DEPTH; a++) ld(0, a, $urandom_range(0, DMOD - 1));
            start = 1'b1;
            ld(1, 0, rand_instr());
            start = 1'b0;
            for (int c = 0; c < 150 && !halted; c++) begin
                out_sel = SW'($urandom_range(0, OC - 1));
                start = ($urandom_range(0, 15) == 0);
                load = ($urandom_range(0, 7) == 0);
                is_instruction = $urandom_range(0, 1) == 1;
                load_address = AW'($urandom);
                instr_input = IW'($urandom);
                cpu_input = DW'($urandom);
`ifdef PARAM_CPU_CORE_STEP_EN
                step = ($urandom_range(0, 3) != 0);
`endif
                if ($urandom_range(0, 199) == 0) pulse_reset();
                else cyc();
            end
            start = 1'b0;
            load = 1'b0;
`ifdef PARAM_CPU_CORE_STEP_EN
            step = 1'b1;
`endif
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
